arm_prog_loader: RTL and testbench
==================================

// Module: arm_prog_loader
// PURPOSE
//  Upstream companion to the ARM core: streams a program image and an initial
//  data image into instruction/data memory over a valid/ready word stream.
//  Holds the core in reset while loading, then releases it and watches pc
//  until the core runs off the end of instruction memory or a cycle budget
//  expires. Replaces bench-side $readmemh preloading with a synthesizable path.
// PARAMETERS
//  INS_MEM_SIZE   32       instruction memory depth, words; halt when pc >= INS_MEM_SIZE*4
//  DATA_MEM_SIZE  64       data memory depth, words
//  MAX_CYCLES     100000   RUN-cycle budget before timeout
// PORTS
//  clk         in   1   clock
//  rst         in   1   synchronous active-high reset
//  start       in   1   1-cycle pulse; honoured only in IDLE or HALT
//  in_valid    in   1   stream word valid
//  in_data     in   32  stream word: INS_MEM_SIZE instr words, then DATA_MEM_SIZE data words
//  in_ready    out  1   loader accepts in_data this cycle
//  pc          in   32  core program counter, byte address
//  ins_we      out  1   instruction memory write enable
//  ins_addr    out  5   instruction memory word address
//  ins_wdata   out  32  instruction memory write data
//  dmem_we     out  1   data memory write enable
//  dmem_addr   out  6   data memory word address
//  dmem_wdata  out  32  data memory write data
//  cpu_rst     out  1   reset to ARM core, active high
//  done        out  1   level; high in HALT
//  timeout     out  1   level; high in HALT if entered by budget expiry
//  cycle_cnt   out  32  RUN cycles elapsed, saturating
// BEHAVIOUR
//  States: IDLE, LOAD_INS, LOAD_DATA, SETTLE, RUN, HALT. All outputs registered.
//  Reset: state=IDLE, in_ready=0, ins_we=0, dmem_we=0, all addr/wdata=0,
//   cpu_rst=1, done=0, timeout=0, cycle_cnt=0, word counter=0.
//  IDLE:  start -> LOAD_INS; word counter cleared.
//  Handshake: a word transfers on a cycle with in_valid && in_ready. in_ready=1
//   only in LOAD_INS/LOAD_DATA. in_data is ignored when in_valid=0.
//  LOAD_INS: word k is written at ins_addr=k. ins_we pulses high for 1 cycle,
//   the cycle after the transfer (1-cycle latency). After transfer of word
//   INS_MEM_SIZE-1: counter clears, next state LOAD_DATA.
//  LOAD_DATA: same rules via dmem_*. After word DATA_MEM_SIZE-1 -> SETTLE.
//  SETTLE: one cycle so the final dmem write lands; cpu_rst is still 1; -> RUN.
//  RUN: cpu_rst=0 from the first RUN cycle. cycle_cnt increments once per
//   RUN cycle and saturates at 32'hFFFF_FFFF.
//   pc >= INS_MEM_SIZE*4 -> HALT, timeout=0.
//   Otherwise, cycle_cnt == MAX_CYCLES-1 -> HALT, timeout=1.
//   If both hold in the same cycle, the pc condition wins (timeout=0).
//  HALT: cpu_rst=1 (core frozen; memory kept for inspection), done=1.
//   cycle_cnt and timeout are held. start -> LOAD_INS: clears done, timeout,
//   cycle_cnt and the counter (full reload).
//  start outside IDLE/HALT is ignored. No back-pressure beyond in_ready.
//  rst in any state, mid-load included, returns to the reset values next
//   cycle. Partially written memory is not scrubbed.
//  Counter width is ceil(log2(max(INS_MEM_SIZE,DATA_MEM_SIZE))). Addresses wrap
//   never occur: the state changes at size-1.
// TESTING
//  1. Reset, start, 32+64 words streamed back-to-back with in_valid=1 ->
//     ins_we at addr 0..31 and dmem_we at addr 0..63, each 1 cycle after its
//     transfer; cpu_rst falls exactly 1 cycle after the last transfer+1 (SETTLE).
//  2. in_valid toggled 1,0,1,0 during LOAD_INS -> writes occur only for
//     accepted words; addresses are contiguous with no gaps or duplicates.
//  3. RUN with pc stepping by 4 to 128 -> HALT on the first cycle pc=128 is
//     sampled; done=1, timeout=0, cpu_rst=1.
//  4. MAX_CYCLES=16, pc stuck at 0 -> HALT after 16 RUN cycles; timeout=1,
//     cycle_cnt=15 held.
//  5. rst asserted after word 40 of stream -> next cycle IDLE, in_ready=0,
//     cpu_rst=1; a new start reloads from ins_addr 0.
//  6. start pulsed in LOAD_DATA -> ignored; start in HALT -> LOAD_INS,
//     done=0, cycle_cnt=0.

Source files
------------

// File: rtl/arm_prog_loader_if.sv
// Stream-in plus instruction/data memory write bus between a program source and the loader.
// Latency: none (wires only); all timing lives in the loader.
// Backpressure: in_ready from the loader gates in_valid/in_data; memory writes cannot be stalled.
interface arm_prog_loader_if #(
   parameter int INS_AW  = 5,
   parameter int DATA_AW = 6
);
   logic               in_valid;
   logic [31:0]        in_data;
   logic               in_ready;
   logic               ins_we;
   logic [INS_AW-1:0]  ins_addr;
   logic [31:0]        ins_wdata;
   logic               dmem_we;
   logic [DATA_AW-1:0] dmem_addr;
   logic [31:0]        dmem_wdata;

   // Word source and memory sink side
   modport master (
      output in_valid, in_data,
      input  in_ready, ins_we, ins_addr, ins_wdata, dmem_we, dmem_addr, dmem_wdata
   );

   // Loader side
   modport slave (
      input  in_valid, in_data,
      output in_ready, ins_we, ins_addr, ins_wdata, dmem_we, dmem_addr, dmem_wdata
   );
endinterface

// File: rtl/arm_prog_loader.sv
// Streams program + data images into core memories, holds core in reset, then runs and watches pc.
// Latency: memory write 1 cycle after each accepted word; core released 2 cycles after last word.
// Backpressure: in_ready high only while loading; every offered word is taken then, none otherwise.
module arm_prog_loader #(
   parameter int INS_MEM_SIZE  = 32,
   parameter int DATA_MEM_SIZE = 64,
   parameter int MAX_CYCLES    = 100000
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_start,
   input  logic [31:0]         i_pc,
   arm_prog_loader_if.slave    io_bus,
   output logic                o_cpu_rst,
   output logic                o_done,
   output logic                o_timeout,
   output logic [31:0]         o_cycle_cnt
);
   localparam int INS_AW  = $clog2(INS_MEM_SIZE);
   localparam int DATA_AW = $clog2(DATA_MEM_SIZE);
   localparam int CNT_W   = (INS_AW > DATA_AW) ? INS_AW : DATA_AW;

   localparam logic [CNT_W-1:0] INS_LAST  = CNT_W'(INS_MEM_SIZE - 1);
   localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_MEM_SIZE - 1);
   // First byte address past the end of instruction memory
   localparam logic [31:0]      PC_END    = 32'(INS_MEM_SIZE * 4);
   localparam logic [31:0]      CYC_LAST  = 32'(MAX_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD_INS,
      S_LOAD_DATA,
      S_SETTLE,
      S_RUN,
      S_HALT
   } state_t;

   state_t               r_state;
   logic [CNT_W-1:0]     r_cnt;
   logic                 r_in_ready;
   logic                 r_ins_we;
   logic [INS_AW-1:0]    r_ins_addr;
   logic [31:0]          r_ins_wdata;
   logic                 r_dmem_we;
   logic [DATA_AW-1:0]   r_dmem_addr;
   logic [31:0]          r_dmem_wdata;
   logic                 r_cpu_rst;
   logic                 r_done;
   logic                 r_timeout;
   logic [31:0]          r_cycle_cnt;

   logic                 w_xfer;

   assign w_xfer = io_bus.in_valid && r_in_ready;

   assign io_bus.in_ready   = r_in_ready;
   assign io_bus.ins_we     = r_ins_we;
   assign io_bus.ins_addr   = r_ins_addr;
   assign io_bus.ins_wdata  = r_ins_wdata;
   assign io_bus.dmem_we    = r_dmem_we;
   assign io_bus.dmem_addr  = r_dmem_addr;
   assign io_bus.dmem_wdata = r_dmem_wdata;
   assign o_cpu_rst         = r_cpu_rst;
   assign o_done            = r_done;
   assign o_timeout         = r_timeout;
   assign o_cycle_cnt       = r_cycle_cnt;

   // Control FSM: every output is a register updated alongside the state
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state      <= S_IDLE;
         r_cnt        <= '0;
         r_in_ready   <= 1'b0;
         r_ins_we     <= 1'b0;
         r_ins_addr   <= '0;
         r_ins_wdata  <= '0;
         r_dmem_we    <= 1'b0;
         r_dmem_addr  <= '0;
         r_dmem_wdata <= '0;
         r_cpu_rst    <= 1'b1;
         r_done       <= 1'b0;
         r_timeout    <= 1'b0;
         r_cycle_cnt  <= '0;
      end else begin
         // Write enables are single-cycle pulses
         r_ins_we  <= 1'b0;
         r_dmem_we <= 1'b0;

         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_state    <= S_LOAD_INS;
                  r_cnt      <= '0;
                  r_in_ready <= 1'b1;
               end
            end

            S_LOAD_INS: begin
               if (w_xfer) begin
                  r_ins_we    <= 1'b1;
                  r_ins_addr  <= r_cnt[INS_AW-1:0];
                  r_ins_wdata <= io_bus.in_data;
                  if (r_cnt == INS_LAST) begin
                     r_cnt   <= '0;
                     r_state <= S_LOAD_DATA;
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
            end

            S_LOAD_DATA: begin
               if (w_xfer) begin
                  r_dmem_we    <= 1'b1;
                  r_dmem_addr  <= r_cnt[DATA_AW-1:0];
                  r_dmem_wdata <= io_bus.in_data;
                  if (r_cnt == DATA_LAST) begin
                     r_cnt      <= '0;
                     r_in_ready <= 1'b0;
                     r_state    <= S_SETTLE;
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
            end

            // Final data write lands this cycle; release the core on the way out
            S_SETTLE: begin
               r_state   <= S_RUN;
               r_cpu_rst <= 1'b0;
            end

            // Running off the end of instruction memory beats the budget check
            S_RUN: begin
               if (i_pc >= PC_END) begin
                  r_state   <= S_HALT;
                  r_cpu_rst <= 1'b1;
                  r_done    <= 1'b1;
                  r_timeout <= 1'b0;
               end else if (r_cycle_cnt == CYC_LAST) begin
                  r_state   <= S_HALT;
                  r_cpu_rst <= 1'b1;
                  r_done    <= 1'b1;
                  r_timeout <= 1'b1;
               end else if (r_cycle_cnt != 32'hFFFF_FFFF) begin
                  r_cycle_cnt <= r_cycle_cnt + 32'd1;
               end
            end

            // Results held until a new start forces a full reload
            S_HALT: begin
               if (i_start) begin
                  r_state     <= S_LOAD_INS;
                  r_cnt       <= '0;
                  r_in_ready  <= 1'b1;
                  r_done      <= 1'b0;
                  r_timeout   <= 1'b0;
                  r_cycle_cnt <= '0;
               end
            end

            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_arm_prog_loader.sv
// Bench for arm_prog_loader: two instances share the stream; the second has a 16-cycle budget.
// Memory writes are scoreboarded against words pushed at the moment they are accepted.
// The bench drives on falling edges and samples on falling edges.
module tb_arm_prog_loader;
   localparam int INS = 32;
   localparam int DAT = 64;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [31:0] pc_a;
   logic [31:0] pc_b;
   logic        cpu_rst_a, done_a, timeout_a;
   logic        cpu_rst_b, done_b, timeout_b;
   logic [31:0] cnt_a, cnt_b;

   always #5 clk = ~clk;

   arm_prog_loader_if #(.INS_AW(5), .DATA_AW(6)) bus_a ();
   arm_prog_loader_if #(.INS_AW(5), .DATA_AW(6)) bus_b ();

   assign bus_b.in_valid = bus_a.in_valid;
   assign bus_b.in_data  = bus_a.in_data;

   arm_prog_loader #(.INS_MEM_SIZE(INS), .DATA_MEM_SIZE(DAT), .MAX_CYCLES(100000)) u_dut_a (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_start     (start),
      .i_pc        (pc_a),
      .io_bus      (bus_a.slave),
      .o_cpu_rst   (cpu_rst_a),
      .o_done      (done_a),
      .o_timeout   (timeout_a),
      .o_cycle_cnt (cnt_a)
   );

   arm_prog_loader #(.INS_MEM_SIZE(INS), .DATA_MEM_SIZE(DAT), .MAX_CYCLES(16)) u_dut_b (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_start     (start),
      .i_pc        (pc_b),
      .io_bus      (bus_b.slave),
      .o_cpu_rst   (cpu_rst_b),
      .o_done      (done_b),
      .o_timeout   (timeout_b),
      .o_cycle_cnt (cnt_b)
   );

   typedef struct {
      bit          is_data;
      logic [5:0]  addr;
      logic [31:0] data;
      int          due;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;
   int   tb_cyc = 0;
   int   k;

   always @(posedge clk) tb_cyc++;

   // Scoreboard: every write pulse must match the oldest accepted word, one cycle after acceptance
   always @(negedge clk) begin
      exp_t e;
      if (bus_a.ins_we) begin
         total++;
         if (sb.size() == 0) begin
            bad++;
            $display("FAIL ins_write_unexpected: got addr=%0d data=%h, required no write", bus_a.ins_addr, bus_a.ins_wdata);
         end else begin
            e = sb.pop_front();
            if (e.is_data || {1'b0, bus_a.ins_addr} !== e.addr || bus_a.ins_wdata !== e.data || tb_cyc != e.due) begin
               bad++;
               $display("FAIL ins_write: got ins addr=%0d data=%h cyc=%0d, required %s addr=%0d data=%h cyc=%0d",
                        bus_a.ins_addr, bus_a.ins_wdata, tb_cyc, e.is_data ? "dmem" : "ins", e.addr, e.data, e.due);
            end
         end
      end
      if (bus_a.dmem_we) begin
         total++;
         if (sb.size() == 0) begin
            bad++;
            $display("FAIL dmem_write_unexpected: got addr=%0d data=%h, required no write", bus_a.dmem_addr, bus_a.dmem_wdata);
         end else begin
            e = sb.pop_front();
            if (!e.is_data || bus_a.dmem_addr !== e.addr || bus_a.dmem_wdata !== e.data || tb_cyc != e.due) begin
               bad++;
               $display("FAIL dmem_write: got dmem addr=%0d data=%h cyc=%0d, required %s addr=%0d data=%h cyc=%0d",
                        bus_a.dmem_addr, bus_a.dmem_wdata, tb_cyc, e.is_data ? "dmem" : "ins", e.addr, e.data, e.due);
            end
         end
      end
   end

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Offer words until n have been accepted; optional valid toggling during instruction load
   task automatic stream(input int n, input bit toggle, input int start_at);
      int   guard;
      bit   phase;
      exp_t e;
      guard = 0;
      phase = 1'b1;
      while (k < n) begin
         @(negedge clk);
         bus_a.in_valid = (toggle && k < INS) ? phase : 1'b1;
         phase          = ~phase;
         bus_a.in_data  = $urandom;
         start          = (k == start_at);
         if (bus_a.in_valid && bus_a.in_ready) begin
            e.is_data = (k >= INS);
            e.addr    = 6'((k < INS) ? k : k - INS);
            e.data    = bus_a.in_data;
            e.due     = tb_cyc + 1;
            sb.push_back(e);
            k++;
         end
         guard++;
         if (guard > 400) begin
            total++;
            bad++;
            $display("FAIL stream_stall: got %0d words accepted, required %0d", k, n);
            break;
         end
      end
      @(negedge clk);
      bus_a.in_valid = 1'b0;
      start          = 1'b0;
   endtask

   task automatic test_reset();
      rst            = 1'b1;
      start          = 1'b0;
      pc_a           = 32'd0;
      pc_b           = 32'd0;
      bus_a.in_valid = 1'b0;
      bus_a.in_data  = 32'd0;
      repeat (3) @(negedge clk);
      total++; if (bus_a.in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready: got %b want 0", bus_a.in_ready); end
      total++; if (bus_a.ins_we !== 1'b0 || bus_a.dmem_we !== 1'b0) begin bad++; $display("FAIL rst_we: got %b%b want 00", bus_a.ins_we, bus_a.dmem_we); end
      total++; if (bus_a.ins_addr !== 5'd0 || bus_a.dmem_addr !== 6'd0) begin bad++; $display("FAIL rst_addr: got %0d/%0d want 0/0", bus_a.ins_addr, bus_a.dmem_addr); end
      total++; if (bus_a.ins_wdata !== 32'd0 || bus_a.dmem_wdata !== 32'd0) begin bad++; $display("FAIL rst_wdata: got %h/%h want 0/0", bus_a.ins_wdata, bus_a.dmem_wdata); end
      total++; if (cpu_rst_a !== 1'b1 || cpu_rst_b !== 1'b1) begin bad++; $display("FAIL rst_cpu_rst: got %b%b want 11", cpu_rst_a, cpu_rst_b); end
      total++; if (done_a !== 1'b0 || timeout_a !== 1'b0) begin bad++; $display("FAIL rst_done_timeout: got %b%b want 00", done_a, timeout_a); end
      total++; if (cnt_a !== 32'd0) begin bad++; $display("FAIL rst_cycle_cnt: got %0d want 0", cnt_a); end
      rst = 1'b0;
      @(negedge clk);
      total++; if (bus_a.in_ready !== 1'b0) begin bad++; $display("FAIL idle_in_ready: got %b want 0", bus_a.in_ready); end
   endtask

   task automatic test_back_to_back();
      k = 0;
      pulse_start();
      total++; if (bus_a.in_ready !== 1'b1) begin bad++; $display("FAIL load_in_ready: got %b want 1", bus_a.in_ready); end
      stream(INS + DAT, 1'b0, -1);
      total++; if (cpu_rst_a !== 1'b1) begin bad++; $display("FAIL b2b_settle_cpu_rst: got %b want 1", cpu_rst_a); end
      total++; if (bus_a.in_ready !== 1'b0) begin bad++; $display("FAIL b2b_settle_in_ready: got %b want 0", bus_a.in_ready); end
      @(negedge clk);
      total++; if (cpu_rst_a !== 1'b0 || cpu_rst_b !== 1'b0) begin bad++; $display("FAIL b2b_run_cpu_rst: got %b%b want 00", cpu_rst_a, cpu_rst_b); end
      total++; if (cnt_a !== 32'd0) begin bad++; $display("FAIL b2b_run_cnt: got %0d want 0", cnt_a); end
      total++; if (sb.size() != 0) begin bad++; $display("FAIL b2b_sb_drained: got %0d pending want 0", sb.size()); end
   endtask

   // A steps pc to the end of instruction memory; B sits at pc 0 and runs out of budget meanwhile
   task automatic test_run_halt();
      for (int j = 1; j <= 32; j++) begin
         @(negedge clk);
         total++; if (done_a !== 1'b0) begin bad++; $display("FAIL run_done_early: got %b want 0 at step %0d", done_a, j); end
         total++; if (cnt_a !== 32'(j)) begin bad++; $display("FAIL run_cycle_cnt: got %0d want %0d", cnt_a, j); end
         if (j == 15) begin
            total++; if (done_b !== 1'b0 || cpu_rst_b !== 1'b0) begin bad++; $display("FAIL budget_early: got done=%b cpu_rst=%b want 0/0", done_b, cpu_rst_b); end
         end
         if (j == 16) begin
            total++; if (done_b !== 1'b1 || timeout_b !== 1'b1) begin bad++; $display("FAIL budget_halt: got done=%b timeout=%b want 1/1", done_b, timeout_b); end
            total++; if (cnt_b !== 32'd15) begin bad++; $display("FAIL budget_cnt: got %0d want 15", cnt_b); end
         end
         pc_a = 32'(4 * j);
      end
      @(negedge clk);
      total++; if (done_a !== 1'b1 || timeout_a !== 1'b0) begin bad++; $display("FAIL pc_halt: got done=%b timeout=%b want 1/0", done_a, timeout_a); end
      total++; if (cpu_rst_a !== 1'b1) begin bad++; $display("FAIL pc_halt_cpu_rst: got %b want 1", cpu_rst_a); end
      total++; if (cnt_a !== 32'd32) begin bad++; $display("FAIL pc_halt_cnt: got %0d want 32", cnt_a); end
      pc_a = 32'd0;
      repeat (3) @(negedge clk);
      total++; if (done_a !== 1'b1 || cnt_a !== 32'd32) begin bad++; $display("FAIL halt_hold: got done=%b cnt=%0d want 1/32", done_a, cnt_a); end
   endtask

   task automatic test_timeout();
      total++; if (done_b !== 1'b1 || timeout_b !== 1'b1) begin bad++; $display("FAIL timeout_hold: got done=%b timeout=%b want 1/1", done_b, timeout_b); end
      total++; if (cnt_b !== 32'd15 || cpu_rst_b !== 1'b1) begin bad++; $display("FAIL timeout_hold_cnt: got cnt=%0d cpu_rst=%b want 15/1", cnt_b, cpu_rst_b); end
   endtask

   // Restart from HALT, gappy instruction load, and a start pulse mid data load that must be ignored
   task automatic test_restart_gaps();
      k = 0;
      pulse_start();
      total++; if (done_a !== 1'b0 || cnt_a !== 32'd0) begin bad++; $display("FAIL restart_clear: got done=%b cnt=%0d want 0/0", done_a, cnt_a); end
      total++; if (bus_a.in_ready !== 1'b1) begin bad++; $display("FAIL restart_in_ready: got %b want 1", bus_a.in_ready); end
      total++; if (timeout_b !== 1'b0 || done_b !== 1'b0 || cnt_b !== 32'd0) begin bad++; $display("FAIL restart_clear_b: got t=%b d=%b cnt=%0d want 0/0/0", timeout_b, done_b, cnt_b); end
      stream(INS + DAT, 1'b1, 50);
      total++; if (cpu_rst_a !== 1'b1 || bus_a.in_ready !== 1'b0) begin bad++; $display("FAIL gaps_settle: got cpu_rst=%b in_ready=%b want 1/0", cpu_rst_a, bus_a.in_ready); end
      @(negedge clk);
      total++; if (cpu_rst_a !== 1'b0) begin bad++; $display("FAIL gaps_run_cpu_rst: got %b want 0", cpu_rst_a); end
      total++; if (sb.size() != 0) begin bad++; $display("FAIL gaps_sb_drained: got %0d pending want 0", sb.size()); end
   endtask

   task automatic test_rst_midload();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      k = 0;
      pulse_start();
      stream(41, 1'b0, -1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      total++; if (bus_a.in_ready !== 1'b0 || cpu_rst_a !== 1'b1) begin bad++; $display("FAIL midrst_state: got in_ready=%b cpu_rst=%b want 0/1", bus_a.in_ready, cpu_rst_a); end
      total++; if (bus_a.ins_we !== 1'b0 || bus_a.dmem_we !== 1'b0 || bus_a.dmem_addr !== 6'd0) begin bad++; $display("FAIL midrst_bus: got we=%b%b addr=%0d want 00/0", bus_a.ins_we, bus_a.dmem_we, bus_a.dmem_addr); end
      total++; if (sb.size() != 0) begin bad++; $display("FAIL midrst_sb: got %0d pending want 0", sb.size()); end
      @(negedge clk);
      total++; if (bus_a.in_ready !== 1'b0) begin bad++; $display("FAIL midrst_idle: got in_ready=%b want 0", bus_a.in_ready); end
      k = 0;
      pulse_start();
      stream(INS + DAT, 1'b0, -1);
      @(negedge clk);
      total++; if (cpu_rst_a !== 1'b0) begin bad++; $display("FAIL reload_run: got cpu_rst=%b want 0", cpu_rst_a); end
      total++; if (sb.size() != 0) begin bad++; $display("FAIL reload_sb_drained: got %0d pending want 0", sb.size()); end
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_run_halt();
      test_timeout();
      test_restart_gaps();
      test_rst_midload();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got no completion by %0t, required finish", $time);
      $fatal(1, "watchdog");
   end
endmodule
